lap_buffer: RTL and testbench

LAP_BUFFER -- requirements
Module: lap_buffer

---
 rtl/lap_pkg.sv | 15 +
 rtl/key_edge.sv | 29 ++
 rtl/lap_buffer.sv | 175 +++++++++++++++++
 tb/tb_lap_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lap_pkg.sv
// Shared definitions for the lap buffer: state encoding, storage depth and
// the default lap-freeze display time.
package lap_pkg;

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    HOLD   = 2'd1,
    RECALL = 2'd2
  } lap_state_e;

  localparam int LAP_DEPTH       = 4;
  localparam int LAP_HOLD_CYCLES = 200000000;
  localparam int LAP_DATA_W      = 16;

endpackage

// File: rtl/key_edge.sv
// One-bit rising-edge detector for a debounced key level.
// An event needs the key to have been sampled low since reset, so a key that
// is already held when reset releases never fires.
module key_edge (
  input  logic CLK,
  input  logic XRST,
  input  logic KEY_I,
  output logic EVT_O
);

  logic prev_q;
  logic armed_q;

  // Sample history and remember once the key has been seen released.
  always_ff @(posedge CLK) begin
    if (XRST) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q <= KEY_I;
      if (!KEY_I) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign EVT_O = KEY_I & ~prev_q & armed_q;

endmodule

// File: rtl/lap_buffer.sv
// Stopwatch lap buffer: captures up to DEPTH lap times, freezes the display
// for HOLD_CYCLES after each capture and lets the user step through stored
// laps in RECALL mode.
module lap_buffer
  import lap_pkg::*;
#(
  parameter int DEPTH       = LAP_DEPTH,
  parameter int HOLD_CYCLES = LAP_HOLD_CYCLES
) (
  input  logic        CLK,
  input  logic        XRST,
  input  logic [15:0] TIME_IN,
  input  logic        RUN,
  input  logic        CLR,
  input  logic        KEY_LAP,
  input  logic        KEY_RECALL,
  output logic [15:0] DATA_OUT,
  output logic [2:0]  LAP_CNT,
  output logic [1:0]  LAP_IDX,
  output logic        FULL,
  output logic        RECALL_MODE
);

  localparam int HW_RAW = $clog2(HOLD_CYCLES + 1);
  localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [2:0]    CNT_MAX   = 3'(DEPTH);

  lap_state_e    state_q, state_d;
  logic [15:0]   data_q, data_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          full_q, full_d;
  logic          rmode_q, rmode_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   entry_q [4];

  logic          wr_en;
  logic [1:0]    wr_ptr;
  logic          lap_ev;
  logic          rcl_ev;
  logic          lap_acc;
  logic          rcl_req;

  key_edge u_lap_edge (
    .CLK   (CLK),
    .XRST  (XRST),
    .KEY_I (KEY_LAP),
    .EVT_O (lap_ev)
  );

  key_edge u_rcl_edge (
    .CLK   (CLK),
    .XRST  (XRST),
    .KEY_I (KEY_RECALL),
    .EVT_O (rcl_ev)
  );

  // A lap is only taken while running, with room left and outside RECALL.
  // A recall press coinciding with a lap press is always dropped.
  assign lap_acc = lap_ev & RUN & (cnt_q < CNT_MAX) & (state_q != RECALL);
  assign rcl_req = rcl_ev & ~lap_ev;

  // Next-state, display and counter logic; CLR overrides every key event.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    wr_en   = 1'b0;
    wr_ptr  = cnt_q[1:0];

    if (CLR) begin
      state_d = LIVE;
      cnt_d   = 3'd0;
      idx_d   = 2'd0;
      hold_d  = '0;
      data_d  = TIME_IN;
    end else if (lap_acc) begin
      wr_en   = 1'b1;
      cnt_d   = cnt_q + 3'd1;
      state_d = HOLD;
      data_d  = TIME_IN;
      hold_d  = HOLD_LOAD;
    end else begin
      case (state_q)
        LIVE: begin
          data_d = TIME_IN;
          if (rcl_req && (cnt_q != 3'd0)) begin
            state_d = RECALL;
            idx_d   = 2'd0;
            data_d  = entry_q[0];
          end
        end
        HOLD: begin
          if (rcl_req && (cnt_q != 3'd0)) begin
            state_d = RECALL;
            idx_d   = 2'd0;
            data_d  = entry_q[0];
            hold_d  = '0;
          end else if (hold_q > HOLD_ONE) begin
            hold_d = hold_q - HOLD_ONE;
          end else begin
            state_d = LIVE;
            hold_d  = '0;
            data_d  = TIME_IN;
          end
        end
        RECALL: begin
          if (rcl_req) begin
            if ({1'b0, idx_q} < (cnt_q - 3'd1)) begin
              idx_d  = idx_q + 2'd1;
              data_d = entry_q[idx_q + 2'd1];
            end else begin
              state_d = LIVE;
              idx_d   = 2'd0;
              data_d  = TIME_IN;
            end
          end
        end
        default: begin
          state_d = LIVE;
          data_d  = TIME_IN;
        end
      endcase
    end

    full_d  = (cnt_d == CNT_MAX);
    rmode_d = (state_d == RECALL);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (XRST) begin
      state_q <= LIVE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs and hold counter.
  always_ff @(posedge CLK) begin
    if (XRST) begin
      data_q  <= 16'd0;
      cnt_q   <= 3'd0;
      idx_q   <= 2'd0;
      full_q  <= 1'b0;
      rmode_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
      rmode_q <= rmode_d;
      hold_q  <= hold_d;
    end
  end

  // Lap entry registers; never cleared, made unreachable by zeroing the count.
  always_ff @(posedge CLK) begin
    if (wr_en && !XRST) begin
      entry_q[wr_ptr] <= TIME_IN;
    end
  end

  assign DATA_OUT    = data_q;
  assign LAP_CNT     = cnt_q;
  assign LAP_IDX     = idx_q;
  assign FULL        = full_q;
  assign RECALL_MODE = rmode_q;

endmodule

// File: tb/tb_lap_buffer.sv
// Self-checking bench for lap_buffer with a short hold time.
module tb_lap_buffer;

  localparam int HC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] t_in = 16'd0;
  logic        run = 1'b0;
  logic        clr = 1'b0;
  logic        kl = 1'b0;
  logic        kr = 1'b0;
  logic [15:0] DATA_OUT;
  logic [2:0]  LAP_CNT;
  logic [1:0]  LAP_IDX;
  logic        FULL;
  logic        RECALL_MODE;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [15:0] m_laps [4];
  int          m_n = 0;
  int          m_mode = 0;   // 0 live, 1 hold, 2 recall
  int          m_hold = 0;
  int          m_idx = 0;
  logic [15:0] m_shown = 16'd0;
  int          m_last_l = -1; // -1: no sample since reset
  int          m_last_r = -1;

  always #5 clk = ~clk;

  lap_buffer #(.DEPTH(4), .HOLD_CYCLES(HC)) dut (
    .CLK         (clk),
    .XRST        (rst),
    .TIME_IN     (t_in),
    .RUN         (run),
    .CLR         (clr),
    .KEY_LAP     (kl),
    .KEY_RECALL  (kr),
    .DATA_OUT    (DATA_OUT),
    .LAP_CNT     (LAP_CNT),
    .LAP_IDX     (LAP_IDX),
    .FULL        (FULL),
    .RECALL_MODE (RECALL_MODE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // Behaviour for one clock edge given the current inputs.
  task automatic model_step();
    bit lev, rev;
    if (rst) begin
      m_n = 0; m_mode = 0; m_hold = 0; m_idx = 0; m_shown = 16'd0;
      m_last_l = -1; m_last_r = -1;
      return;
    end
    lev = kl && (m_last_l == 0);
    rev = kr && (m_last_r == 0);
    m_last_l = kl ? 1 : 0;
    m_last_r = kr ? 1 : 0;
    if (clr) begin
      m_n = 0; m_idx = 0; m_mode = 0; m_hold = 0; m_shown = t_in;
    end else if (lev && run && m_n < 4 && m_mode != 2) begin
      m_laps[m_n] = t_in;
      m_n++;
      m_mode = 1; m_hold = HC; m_shown = t_in;
    end else if (rev && !lev && m_mode != 2 && m_n > 0) begin
      m_mode = 2; m_idx = 0; m_hold = 0; m_shown = m_laps[0];
    end else if (rev && !lev && m_mode == 2) begin
      if (m_idx + 1 < m_n) begin
        m_idx++;
        m_shown = m_laps[m_idx];
      end else begin
        m_mode = 0; m_idx = 0; m_shown = t_in;
      end
    end else if (m_mode == 1) begin
      m_hold--;
      if (m_hold == 0) begin
        m_mode = 0; m_shown = t_in;
      end
    end else if (m_mode == 0) begin
      m_shown = t_in;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("data_out", 32'(DATA_OUT), 32'(m_shown));
    chk("lap_cnt", 32'(LAP_CNT), 32'(m_n));
    chk("lap_idx", 32'(LAP_IDX), 32'(m_idx));
    chk("full", 32'(FULL), 32'(m_n == 4));
    chk("recall_mode", 32'(RECALL_MODE), 32'(m_mode == 2));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic lap_pulse(input logic [15:0] v);
    t_in = v; kl = 1'b1; step();
    kl = 1'b0; t_in = 16'($urandom); step();
  endtask

  task automatic rcl_pulse();
    kr = 1'b1; step();
    kr = 1'b0; step();
  endtask

  task automatic do_clear();
    clr = 1'b1; step();
    clr = 1'b0; step();
  endtask

  initial begin
    // reset
    rst = 1'b1; steps(3);
    chk("rst_data", 32'(DATA_OUT), 32'h0);
    chk("rst_cnt", 32'(LAP_CNT), 32'h0);
    chk("rst_rmode", 32'(RECALL_MODE), 32'h0);
    rst = 1'b0; run = 1'b1; steps(2);

    // single lap with freeze and release
    t_in = 16'h0123; kl = 1'b1; step();
    chk("lap1_cnt", 32'(LAP_CNT), 32'd1);
    chk("lap1_frz", 32'(DATA_OUT), 32'h0123);
    kl = 1'b0;
    for (int i = 0; i < HC - 1; i++) begin
      t_in = 16'($urandom); step();
      chk("hold_frz", 32'(DATA_OUT), 32'h0123);
    end
    t_in = 16'h4567; step();
    chk("hold_exit", 32'(DATA_OUT), 32'h4567);
    t_in = 16'h89ab; step();
    chk("live_track", 32'(DATA_OUT), 32'h89ab);

    // fill, overflow ignored, then recall all
    do_clear();
    for (int i = 1; i <= 5; i++) lap_pulse(16'(i));
    chk("fill_cnt", 32'(LAP_CNT), 32'd4);
    chk("fill_full", 32'(FULL), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      kr = 1'b1; step();
      chk("recall_val", 32'(DATA_OUT), 32'(i));
      chk("recall_mode_on", 32'(RECALL_MODE), 32'd1);
      kr = 1'b0; step();
    end
    t_in = 16'h0999; kr = 1'b1; step();
    chk("recall_exit", 32'(RECALL_MODE), 32'd0);
    chk("recall_exit_data", 32'(DATA_OUT), 32'h0999);
    kr = 1'b0; step();

    // recall with no laps
    do_clear();
    rcl_pulse();
    chk("empty_recall", 32'(RECALL_MODE), 32'd0);

    // simultaneous lap and recall
    lap_pulse(16'h1111);
    t_in = 16'h2222; kl = 1'b1; kr = 1'b1; step();
    chk("both_cnt", 32'(LAP_CNT), 32'd2);
    chk("both_rmode", 32'(RECALL_MODE), 32'd0);
    chk("both_frz", 32'(DATA_OUT), 32'h2222);
    kl = 1'b0; kr = 1'b0; steps(2);

    // clear in recall over a recall edge
    rcl_pulse(); rcl_pulse();
    chk("pre_clr_idx", 32'(LAP_IDX), 32'd1);
    t_in = 16'h3333; clr = 1'b1; kr = 1'b1; step();
    chk("clr_cnt", 32'(LAP_CNT), 32'd0);
    chk("clr_idx", 32'(LAP_IDX), 32'd0);
    chk("clr_full", 32'(FULL), 32'd0);
    chk("clr_rmode", 32'(RECALL_MODE), 32'd0);
    clr = 1'b0; kr = 1'b0; steps(2);

    // held lap key gives one capture; reset mid-hold
    kl = 1'b1;
    for (int i = 0; i < 50; i++) begin
      t_in = 16'($urandom); step();
    end
    chk("held_once", 32'(LAP_CNT), 32'd1);
    kl = 1'b0; step();
    lap_pulse(16'h7777); step();
    rst = 1'b1; step();
    chk("rst_hold_data", 32'(DATA_OUT), 32'h0);
    chk("rst_hold_cnt", 32'(LAP_CNT), 32'h0);
    // key held through reset release
    kl = 1'b1; step();
    rst = 1'b0; steps(4);
    chk("held_rst_cnt", 32'(LAP_CNT), 32'd0);
    kl = 1'b0; step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      clr  = ($urandom_range(0, 59) == 0);
      run  = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 2) == 0) kl = ~kl;
      if ($urandom_range(0, 2) == 0) kr = ~kr;
      t_in = 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
